// File: rtl/vif_rr_scheduler.sv
// Round-robin scheduler: NUM_REQ valid/data/ready requesters share one
// registered valid/data/ready output channel. Fair rotating priority starts
// just after the last winner, and a drain plus a capture can happen in the
// same cycle, which sustains one transfer per cycle.
module vif_rr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [SRC_W-1:0]              out_src,
  output logic [15:0]                   xfer_count
);

  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [SRC_W-1:0]      src_p0;
  logic [SRC_W-1:0]      last_grant;
  logic [SRC_W-1:0]      winner;
  logic [DATA_WIDTH-1:0] data_sel;
  logic                  hit;
  logic                  any_valid;
  logic                  accept;
  logic                  capture;

  // The output register can take new data when it is empty or draining now.
  // Readies are held low while reset is asserted so that no producer believes
  // it handed off a word that the register is about to discard.
  assign any_valid = |req_valid;
  assign accept    = !vld_p0 || out_ready;
  assign capture   = rst_n && accept && any_valid;

  // Rotating search: first valid requester strictly after last_grant, wrapping.
  always_comb begin
    winner   = last_grant;
    hit      = 1'b0;
    data_sel = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!hit && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        hit    = 1'b1;
        winner = SRC_W'((int'(last_grant) + k) % NUM_REQ);
      end
    end
    data_sel = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Ready goes only to the winner and only when its word is actually taken.
  always_comb begin
    req_ready = '0;
    if (capture) req_ready[winner] = 1'b1;
  end

  // ---- stage p0: output register driving the shared channel ----
  // Capture has priority over drain so back-to-back transfers leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      data_p0    <= '0;
      src_p0     <= '0;
      last_grant <= SRC_W'(NUM_REQ - 1);
    end else if (capture) begin
      vld_p0     <= 1'b1;
      data_p0    <= data_sel;
      src_p0     <= winner;
      last_grant <= winner;
    end else if (vld_p0 && out_ready) begin
      vld_p0     <= 1'b0;
    end
  end

  // Count completed output handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= 16'd0;
    end else if (vld_p0 && out_ready) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_src   = src_p0;

endmodule
